controlador_de_partida: RTL



---
 rtl/controlador_de_partida.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/controlador_de_partida.sv
// Battleship match sequencer: latches the ship map, evaluates attacks, tracks hits/lives and win/lose.
// Optional shot counter output 'tiros' is enabled by defining CONTADOR_TIROS_EN.
module controlador_de_partida #(
  parameter int VIDA_INICIAL = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       confirmar,
  input  logic [2:0] coordColuna,
  input  logic [2:0] coordLinha,
  input  logic [6:0] mapa0,
  input  logic [6:0] mapa1,
  input  logic [6:0] mapa2,
  input  logic [6:0] mapa3,
  input  logic [6:0] mapa4,
  output logic [6:0] matriz0,
  output logic [6:0] matriz1,
  output logic [6:0] matriz2,
  output logic [6:0] matriz3,
  output logic [6:0] matriz4,
  output logic [2:0] vida,
  output logic [5:0] alvos,
  output logic [2:0] estado,
  output logic       LED_R,
  output logic       LED_G,
  output logic       LED_B,
  output logic       venceu,
  output logic       perdeu
`ifdef CONTADOR_TIROS_EN
  ,
  output logic [5:0] tiros
`endif
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    JOGANDO = 3'd1,
    AVALIA  = 3'd2,
    VITORIA = 3'd3,
    DERROTA = 3'd4
  } estado_t;

  estado_t    estado_q;
  logic       conf_q;
  logic [2:0] col_q;
  logic [2:0] lin_q;
  logic [6:0] mapa_q   [5];
  logic [6:0] matriz_q [5];
  logic [6:0] mapa_in  [5];
  logic [5:0] popcount;
  logic       evento;
  logic       invalido;
  logic       repetido;
  logic       bit_navio;
  logic [6:0] col_mapa;
  logic [6:0] col_matriz;
  logic [6:0] mascara;

  assign mapa_in[0] = mapa0;
  assign mapa_in[1] = mapa1;
  assign mapa_in[2] = mapa2;
  assign mapa_in[3] = mapa3;
  assign mapa_in[4] = mapa4;

  assign matriz0 = matriz_q[0];
  assign matriz1 = matriz_q[1];
  assign matriz2 = matriz_q[2];
  assign matriz3 = matriz_q[3];
  assign matriz4 = matriz_q[4];

  assign estado = estado_q;
  assign venceu = (estado_q == VITORIA);
  assign perdeu = (estado_q == DERROTA);
  assign evento = confirmar & ~conf_q;

  // Number of ship cells on the live map; zero means there is nothing to play.
  always_comb begin
    popcount = '0;
    for (int c = 0; c < 5; c++) begin
      for (int r = 0; r < 7; r++) begin
        popcount = popcount + {5'd0, mapa_in[c][r]};
      end
    end
  end

  // Column selected by the latched coordinate; out-of-range columns read as empty.
  always_comb begin
    col_mapa   = '0;
    col_matriz = '0;
    for (int c = 0; c < 5; c++) begin
      if (col_q == 3'(c)) begin
        col_mapa   = mapa_q[c];
        col_matriz = matriz_q[c];
      end
    end
  end

  assign invalido  = (col_q > 3'd4) || (lin_q > 3'd6);
  assign mascara   = 7'd1 << lin_q;
  assign bit_navio = |(col_mapa & mascara);
  assign repetido  = |(col_matriz & mascara);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      conf_q   <= 1'b0;
      col_q    <= '0;
      lin_q    <= '0;
      vida     <= '0;
      alvos    <= '0;
      LED_R    <= 1'b0;
      LED_G    <= 1'b0;
      LED_B    <= 1'b0;
      for (int c = 0; c < 5; c++) begin
        mapa_q[c]   <= '0;
        matriz_q[c] <= '0;
      end
`ifdef CONTADOR_TIROS_EN
      tiros <= '0;
`endif
    end else begin
      conf_q <= confirmar;
      case (estado_q)
        OCIOSO, VITORIA, DERROTA: begin
          if (iniciar && (popcount != 6'd0)) begin
            for (int c = 0; c < 5; c++) begin
              mapa_q[c]   <= mapa_in[c];
              matriz_q[c] <= '0;
            end
            vida     <= VIDA_INICIAL[2:0];
            alvos    <= popcount;
            LED_R    <= 1'b0;
            LED_G    <= 1'b0;
            LED_B    <= 1'b0;
            estado_q <= JOGANDO;
`ifdef CONTADOR_TIROS_EN
            tiros <= '0;
`endif
          end
        end
        JOGANDO: begin
          if (evento) begin
            col_q    <= coordColuna;
            lin_q    <= coordLinha;
            estado_q <= AVALIA;
          end
        end
        AVALIA: begin
          if (invalido || repetido) begin
            LED_R    <= 1'b0;
            LED_G    <= 1'b0;
            LED_B    <= 1'b1;
            estado_q <= JOGANDO;
          end else begin
            for (int c = 0; c < 5; c++) begin
              if (col_q == 3'(c)) begin
                matriz_q[c] <= matriz_q[c] | mascara;
              end
            end
`ifdef CONTADOR_TIROS_EN
            if (tiros != 6'd63) begin
              tiros <= tiros + 6'd1;
            end
`endif
            LED_B <= 1'b0;
            // Counters are nonzero in AVALIA, so reaching 1 here means this shot ends the match.
            if (bit_navio) begin
              alvos    <= alvos - 6'd1;
              LED_G    <= 1'b1;
              LED_R    <= 1'b0;
              estado_q <= (alvos == 6'd1) ? VITORIA : JOGANDO;
            end else begin
              vida     <= vida - 3'd1;
              LED_R    <= 1'b1;
              LED_G    <= 1'b0;
              estado_q <= (vida == 3'd1) ? DERROTA : JOGANDO;
            end
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

endmodule
